// File: rtl/dino_pkg.sv
// Shared Dino-game types: scheduler states, obstacle kinds and LFSR width.
package dino_pkg;

  localparam int RND_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    GAP   = 2'd2,
    SPAWN = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    OBS_CACTUS_S    = 2'd0,
    OBS_CACTUS_L    = 2'd1,
    OBS_CACTUS_PAIR = 2'd2,
    OBS_BIRD        = 2'd3
  } obs_type_t;

endpackage

// File: rtl/spawn_gap_timer.sv
// Frame-tick down-counter for the inter-obstacle gap; expire flags the tick
// that consumes the last remaining gap tick.
module spawn_gap_timer #(
  parameter int GW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [GW-1:0] load_val_i,
  input  logic          tick_i,
  input  logic          clear_i,
  output logic          expire_o
);

  logic [GW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = tick_i && (cnt_q == GW'(1));

endmodule

// File: rtl/obstacle_scheduler.sv
// Draws a random obstacle type and gap, waits the gap out in frame ticks and
// offers the spawn over valid/ready. Optional macro: SPAWN_SPEEDUP_EN.
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int MIN_GAP        = 20,
  parameter int GAP_FLOOR      = 8,
  parameter int SPEEDUP_PERIOD = 8,
  parameter int GW             = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             tick,
  input  logic [RND_W-1:0] rnd,
  output logic             rng_step,
  output logic             spawn_valid,
  input  logic             spawn_ready,
  output logic [1:0]       spawn_type,
  output logic [GW-1:0]    min_gap,
  output logic             busy,
  output logic             rng_fault
);

  localparam logic [GW-1:0] MG    = GW'(MIN_GAP);
  localparam logic [GW-1:0] FLOOR = GW'(GAP_FLOOR);

  if (GAP_FLOOR < 1 || MIN_GAP < GAP_FLOOR || SPEEDUP_PERIOD < 1 ||
      MIN_GAP + 7 >= (1 << GW)) begin : g_bad_cfg
    $error("obstacle_scheduler: illegal parameter combination");
  end

  sched_state_t  state_q, state_d;
  obs_type_t     type_q, type_d;
  logic          fault_q, fault_d;
  logic          rng_step_q, spawn_valid_q, busy_q;
  logic [GW-1:0] cur_min_gap;
  logic          timer_load, timer_clear, timer_tick, timer_expire;

  assign timer_tick  = tick && (state_q == GAP);
  assign timer_clear = !run;

  spawn_gap_timer #(.GW(GW)) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (cur_min_gap + GW'(rnd[2:0])),
    .tick_i     (timer_tick),
    .clear_i    (timer_clear),
    .expire_o   (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    fault_d    = fault_q;
    timer_load = 1'b0;
    // A zero LFSR word means lock-up; it is flagged whether or not run holds.
    if (state_q == DRAW && rnd == '0) begin
      fault_d = 1'b1;
    end
    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = DRAW;
        DRAW: begin
          timer_load = 1'b1;
          type_d     = obs_type_t'(rnd[4:3]);
          state_d    = GAP;
        end
        GAP:   if (timer_expire) state_d = SPAWN;
        SPAWN: if (spawn_ready) state_d = DRAW;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // coincide with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      type_q        <= OBS_CACTUS_S;
      fault_q       <= 1'b0;
      rng_step_q    <= 1'b0;
      spawn_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      fault_q       <= fault_d;
      rng_step_q    <= (state_d == DRAW);
      spawn_valid_q <= (state_d == SPAWN);
      busy_q        <= (state_d != IDLE);
    end
  end

`ifdef SPAWN_SPEEDUP_EN
  localparam int             SPW     = $clog2(SPEEDUP_PERIOD + 1);
  localparam logic [SPW-1:0] SP_LAST = SPW'(SPEEDUP_PERIOD - 1);

  logic [SPW-1:0] spd_cnt_q, spd_cnt_d;
  logic [GW-1:0]  min_gap_q, min_gap_d;
  logic           accept;

  assign accept = run && (state_q == SPAWN) && spawn_ready;

  always_comb begin
    spd_cnt_d = spd_cnt_q;
    min_gap_d = min_gap_q;
    if (!run) begin
      spd_cnt_d = '0;
      min_gap_d = MG;
    end else if (accept) begin
      if (spd_cnt_q == SP_LAST) begin
        spd_cnt_d = '0;
        if (min_gap_q > FLOOR) min_gap_d = min_gap_q - GW'(1);
      end else begin
        spd_cnt_d = spd_cnt_q + SPW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_cnt_q <= '0;
      min_gap_q <= MG;
    end else begin
      spd_cnt_q <= spd_cnt_d;
      min_gap_q <= min_gap_d;
    end
  end

  assign cur_min_gap = min_gap_q;
`else
  assign cur_min_gap = MG;
`endif

  assign rng_step    = rng_step_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_type  = type_q;
  assign busy        = busy_q;
  assign rng_fault   = fault_q;
  assign min_gap     = cur_min_gap;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scenario bench for obstacle_scheduler: expected spawns are queued at each
// draw and checked against the measured tick gap when spawn_valid rises.
module tb_obstacle_scheduler;

  localparam int GW   = 8;
  localparam int MAXT = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          tick = 1'b0;
  logic [4:0]    rnd = 5'd0;
  logic          spawn_ready = 1'b0;
  logic          rng_step, spawn_valid, busy, rng_fault;
  logic [1:0]    spawn_type;
  logic [GW-1:0] min_gap;

  obstacle_scheduler #(
    .MIN_GAP(20), .GAP_FLOOR(8), .SPEEDUP_PERIOD(8), .GW(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .tick(tick), .rnd(rnd),
    .rng_step(rng_step), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_type(spawn_type), .min_gap(min_gap), .busy(busy), .rng_fault(rng_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] typ;
    int         gap;
  } exp_t;

  exp_t sbq[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   acc = 0;

  function automatic int exp_min(input int accepted);
`ifdef SPAWN_SPEEDUP_EN
    int m;
    m = 20 - accepted / 8;
    return (m < 8) ? 8 : m;
`else
    return 20 + 0 * accepted;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues ticks every other cycle until spawn_valid rises; n = -1 on timeout.
  task automatic wait_spawn(output int n, output bit extra_step);
    n = 0;
    extra_step = 1'b0;
    repeat (MAXT) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      n++;
      if (rng_step) extra_step = 1'b1;
      if (spawn_valid) return;
      cycle();
      if (rng_step) extra_step = 1'b1;
      if (spawn_valid) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; tick = 1'b0; spawn_ready = 1'b0; rnd = 5'd0;
    cycle();
    tests_run++; if (rng_step !== 1'b0) begin tests_failed++; $display("FAIL reset_rng_step: got %b want 0", rng_step); end
    tests_run++; if (spawn_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_spawn_valid: got %b want 0", spawn_valid); end
    tests_run++; if (spawn_type !== 2'd0) begin tests_failed++; $display("FAIL reset_spawn_type: got %0d want 0", spawn_type); end
    tests_run++; if (min_gap !== 8'd20) begin tests_failed++; $display("FAIL reset_min_gap: got %0d want 20", min_gap); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (rng_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_rng_fault: got %b want 0", rng_fault); end
    rst_n = 1'b1;
    acc = 0;
    cycle();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_first_spawn();
    exp_t e;
    int   n;
    bit   x;
    rnd = 5'b10110;
    run = 1'b1;
    cycle();
    tests_run++; if (rng_step !== 1'b1) begin tests_failed++; $display("FAIL first_rng_step: got %b want 1", rng_step); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL first_busy: got %b want 1", busy); end
    sbq.push_back('{typ: 2'd2, gap: exp_min(acc) + 6});
    cycle();
    tests_run++; if (rng_step !== 1'b0) begin tests_failed++; $display("FAIL first_step_width: got %b want 0", rng_step); end
    wait_spawn(n, x);
    tests_run++; if (x !== 1'b0) begin tests_failed++; $display("FAIL first_extra_step: got %b want 0", x); end
    e = sbq.pop_front();
    tests_run++; if (n !== e.gap) begin tests_failed++; $display("FAIL first_gap: got %0d want %0d", n, e.gap); end
    tests_run++; if (spawn_type !== e.typ) begin tests_failed++; $display("FAIL first_type: got %0d want %0d", spawn_type, e.typ); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    bit   x;
    for (int c = 0; c < 10; c++) begin
      tick = (c == 2 || c == 5 || c == 8);
      cycle();
      tick = 1'b0;
      tests_run++; if (spawn_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_valid c%0d: got %b want 1", c, spawn_valid); end
      tests_run++; if (spawn_type !== 2'd2) begin tests_failed++; $display("FAIL hold_type c%0d: got %0d want 2", c, spawn_type); end
    end
    rnd = 5'b01011;
    spawn_ready = 1'b1;
    cycle();
    spawn_ready = 1'b0;
    acc++;
    tests_run++; if (rng_step !== 1'b1) begin tests_failed++; $display("FAIL hs_rng_step: got %b want 1", rng_step); end
    tests_run++; if (spawn_valid !== 1'b0) begin tests_failed++; $display("FAIL hs_valid_drop: got %b want 0", spawn_valid); end
    sbq.push_back('{typ: 2'd1, gap: exp_min(acc) + 3});
    cycle();
    tests_run++; if (rng_step !== 1'b0) begin tests_failed++; $display("FAIL hs_step_width: got %b want 0", rng_step); end
    wait_spawn(n, x);
    e = sbq.pop_front();
    tests_run++; if (n !== e.gap) begin tests_failed++; $display("FAIL second_gap: got %0d want %0d", n, e.gap); end
    tests_run++; if (spawn_type !== e.typ) begin tests_failed++; $display("FAIL second_type: got %0d want %0d", spawn_type, e.typ); end
  endtask

  task automatic test_retract();
    exp_t e;
    int   n;
    bit   x;
    run = 1'b0;
    spawn_ready = 1'b1;
    cycle();
    spawn_ready = 1'b0;
    acc = 0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL retract_spawn_busy: got %b want 0", busy); end
    tests_run++; if (spawn_valid !== 1'b0) begin tests_failed++; $display("FAIL retract_spawn_valid: got %b want 0", spawn_valid); end
    rnd = 5'b11001;
    run = 1'b1;
    cycle();
    tests_run++; if (rng_step !== 1'b1) begin tests_failed++; $display("FAIL restart_rng_step: got %b want 1", rng_step); end
    tests_run++; if (min_gap !== 8'd20) begin tests_failed++; $display("FAIL restart_min_gap: got %0d want 20", min_gap); end
    sbq.push_back('{typ: 2'd3, gap: exp_min(acc) + 1});
    cycle();
    repeat (5) begin
      tick = 1'b1; cycle(); tick = 1'b0; cycle();
    end
    run = 1'b0;
    cycle();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL retract_gap_busy: got %b want 0", busy); end
    tests_run++; if (spawn_valid !== 1'b0) begin tests_failed++; $display("FAIL retract_gap_valid: got %b want 0", spawn_valid); end
    e = sbq.pop_front();
    run = 1'b1;
    cycle();
    sbq.push_back('{typ: 2'd3, gap: exp_min(acc) + 1});
    cycle();
    wait_spawn(n, x);
    e = sbq.pop_front();
    tests_run++; if (n !== e.gap) begin tests_failed++; $display("FAIL regap_full: got %0d want %0d", n, e.gap); end
    tests_run++; if (spawn_type !== e.typ) begin tests_failed++; $display("FAIL regap_type: got %0d want %0d", spawn_type, e.typ); end
  endtask

  task automatic test_fault();
    exp_t e;
    int   n;
    bit   x;
    run = 1'b0;
    cycle();
    acc = 0;
    rnd = 5'b00000;
    run = 1'b1;
    cycle();
    sbq.push_back('{typ: 2'd0, gap: exp_min(acc)});
    cycle();
    tests_run++; if (rng_fault !== 1'b1) begin tests_failed++; $display("FAIL fault_set: got %b want 1", rng_fault); end
    wait_spawn(n, x);
    e = sbq.pop_front();
    tests_run++; if (n !== e.gap) begin tests_failed++; $display("FAIL fault_gap: got %0d want %0d", n, e.gap); end
    tests_run++; if (spawn_type !== e.typ) begin tests_failed++; $display("FAIL fault_type: got %0d want %0d", spawn_type, e.typ); end
    run = 1'b0;
    cycle();
    tests_run++; if (rng_fault !== 1'b1) begin tests_failed++; $display("FAIL fault_sticky_off: got %b want 1", rng_fault); end
    rnd = 5'b00101;
    run = 1'b1;
    cycle();
    cycle();
    tests_run++; if (rng_fault !== 1'b1) begin tests_failed++; $display("FAIL fault_sticky_on: got %b want 1", rng_fault); end
    run = 1'b0;
    rst_n = 1'b0;
    cycle();
    tests_run++; if (rng_fault !== 1'b0) begin tests_failed++; $display("FAIL fault_clear: got %b want 0", rng_fault); end
    rst_n = 1'b1;
    acc = 0;
    cycle();
  endtask

  task automatic test_speedup();
    exp_t       e;
    int         n;
    bit         x;
    logic [1:0] t;
    t = 2'($urandom_range(1, 3));
    rnd = {t, 3'b000};
    run = 1'b1;
    cycle();
    for (int i = 0; i < 200; i++) begin
      tests_run++; if (rng_step !== 1'b1) begin tests_failed++; $display("FAIL sp_step i%0d: got %b want 1", i, rng_step); end
      sbq.push_back('{typ: rnd[4:3], gap: exp_min(acc)});
      cycle();
      wait_spawn(n, x);
      if (sbq.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL sp_queue i%0d: got empty want entry", i);
      end else begin
        e = sbq.pop_front();
        tests_run++; if (n !== e.gap) begin tests_failed++; $display("FAIL sp_gap i%0d: got %0d want %0d", i, n, e.gap); end
        tests_run++; if (spawn_type !== e.typ) begin tests_failed++; $display("FAIL sp_type i%0d: got %0d want %0d", i, spawn_type, e.typ); end
      end
      t = 2'($urandom_range(1, 3));
      rnd = {t, 3'b000};
      spawn_ready = 1'b1;
      cycle();
      spawn_ready = 1'b0;
      acc++;
      tests_run++; if (min_gap !== GW'(exp_min(acc))) begin tests_failed++; $display("FAIL sp_min_gap acc%0d: got %0d want %0d", acc, min_gap, exp_min(acc)); end
    end
    run = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_backpressure();
    test_retract();
    test_fault();
    test_speedup();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
